// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for a 5-stage RISC pipeline.
// Captures decoded operands (with write-back bypass), detects the classic
// load-use hazard against the instruction currently in EX, and inserts a
// single bubble when needed. Also honours downstream hold and branch flush.
//
// Control word layout (id_ctrl / ex_ctrl):
//   [8] reg_write  [7] mem_read  [6] mem_write  [5] mem_to_reg
//   [4] alu_src    [3] reg_dst   [2:0] alu_op
//
// Stage handshake: the stage accepts the decode-side instruction on a rising
// edge only when stall_id is low and no flush is in progress; when stall_id
// is high the upstream PC and IF/ID register must present the same
// instruction again on the next cycle. ex_hold is the downstream "not
// ready" and freezes every register in this stage, including bubble_count.

module id_ex_stage (
  input  logic        clk,
  input  logic        reset,

  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_pc4,
  input  logic        id_uses_rt,
  input  logic [8:0]  id_ctrl,

  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,

  input  logic        ex_hold,
  input  logic        ex_flush,

  output logic        stall_id,

  output logic        ex_valid,
  output logic [8:0]  ex_ctrl,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_pc4,

  output logic [15:0] bubble_count
);

  // Bit positions inside the control word.
  localparam int CTRL_REG_WRITE = 8;
  localparam int CTRL_MEM_READ  = 7;
  localparam int CTRL_MEM_WRITE = 6;

  localparam logic [15:0] BUBBLE_MAX = 16'hFFFF;

  // What the register bank does on the coming edge, in priority order.
  typedef enum logic [2:0] {
    ACT_RESET   = 3'd0,
    ACT_FLUSH   = 3'd1,
    ACT_HOLD    = 3'd2,
    ACT_BUBBLE  = 3'd3,
    ACT_CAPTURE = 3'd4
  } action_t;

  action_t     action;
  logic        ex_mem_read;
  logic        rs_match;
  logic        rt_match;
  logic        load_use;
  logic        wb_active;
  logic [31:0] rs_bypassed;
  logic [31:0] rt_bypassed;

  // Load-use detection against the instruction currently in EX.
  always_comb begin
    ex_mem_read = ex_ctrl[CTRL_MEM_READ];
    rs_match    = (ex_rt == id_rs);
    rt_match    = id_uses_rt && (ex_rt == id_rt);
    load_use    = ex_valid && ex_mem_read && (ex_rt != 5'd0) && id_valid &&
                  (rs_match || rt_match);
  end

  // Stall request to IF/ID; forced low while the stage is being reset.
  always_comb begin
    stall_id = !reset && (load_use || ex_hold);
  end

  // Write-back bypass: the register file is read and written in the same
  // cycle, so the freshly written value wins over the stale read data.
  always_comb begin
    wb_active   = wb_reg_write && (wb_write_reg != 5'd0);
    rs_bypassed = (wb_active && (wb_write_reg == id_rs)) ? wb_write_data : id_rs_data;
    rt_bypassed = (wb_active && (wb_write_reg == id_rt)) ? wb_write_data : id_rt_data;
  end

  // Edge action selection: reset > flush > hold > hazard bubble > capture.
  always_comb begin
    action = ACT_CAPTURE;
    if (reset) begin
      action = ACT_RESET;
    end else if (ex_flush) begin
      action = ACT_FLUSH;
    end else if (ex_hold) begin
      action = ACT_HOLD;
    end else if (load_use) begin
      action = ACT_BUBBLE;
    end
  end

  // EX-stage valid and control; flush and bubble both zero the whole
  // control word so no write or memory strobe can leak from a squashed slot.
  always_ff @(posedge clk) begin
    case (action)
      ACT_RESET: begin
        ex_valid <= 1'b0;
        ex_ctrl  <= 9'd0;
      end
      ACT_FLUSH, ACT_BUBBLE: begin
        ex_valid <= 1'b0;
        ex_ctrl  <= 9'd0;
      end
      ACT_HOLD: begin
        ex_valid <= ex_valid;
        ex_ctrl  <= ex_ctrl;
      end
      default: begin
        ex_valid <= id_valid;
        ex_ctrl  <= id_valid ? id_ctrl : 9'd0;
      end
    endcase
  end

  // EX-stage operand and index fields; left untouched by flush and bubble
  // because ex_valid/ex_ctrl already mark the slot as empty.
  always_ff @(posedge clk) begin
    case (action)
      ACT_RESET: begin
        ex_rs      <= 5'd0;
        ex_rt      <= 5'd0;
        ex_rd      <= 5'd0;
        ex_rs_data <= 32'd0;
        ex_rt_data <= 32'd0;
        ex_imm     <= 32'd0;
        ex_pc4     <= 32'd0;
      end
      ACT_CAPTURE: begin
        ex_rs      <= id_rs;
        ex_rt      <= id_rt;
        ex_rd      <= id_rd;
        ex_rs_data <= rs_bypassed;
        ex_rt_data <= rt_bypassed;
        ex_imm     <= id_imm;
        ex_pc4     <= id_pc4;
      end
      default: begin
        ex_rs      <= ex_rs;
        ex_rt      <= ex_rt;
        ex_rd      <= ex_rd;
        ex_rs_data <= ex_rs_data;
        ex_rt_data <= ex_rt_data;
        ex_imm     <= ex_imm;
        ex_pc4     <= ex_pc4;
      end
    endcase
  end

  // Saturating count of load-use bubbles actually inserted.
  always_ff @(posedge clk) begin
    if (action == ACT_RESET) begin
      bubble_count <= 16'd0;
    end else if ((action == ACT_BUBBLE) && (bubble_count != BUBBLE_MAX)) begin
      bubble_count <= bubble_count + 16'd1;
    end
  end

  // Safety properties on the registered outputs.
  always_ff @(posedge clk) begin
    if (!reset && !ex_valid) begin
      assert (ex_ctrl[CTRL_REG_WRITE] == 1'b0 && ex_ctrl[CTRL_MEM_READ] == 1'b0 &&
              ex_ctrl[CTRL_MEM_WRITE] == 1'b0)
        else $error("empty EX slot carries an active write or memory strobe");
    end
  end

endmodule
